// File: rtl/mem_split_interface.sv
// mem_split_interface: core load/store port onto a word bus, splitting lane-crossing accesses into two beats.
// Define MEM_SPLIT_MISALIGN_EN to enable splitting; otherwise crossing accesses raise malign.
module mem_split_interface #(
  parameter int DataWidth        = 32,
  parameter int ByteSize         = 8,
  parameter int ByteAddressWidth = 32
) (
  input  logic                                                          clk,
  input  logic                                                          rst_n,
  input  logic                                                          bus_available,
  output logic [ByteAddressWidth-$clog2(DataWidth/ByteSize)-1:0]        bus_address,
  output logic [DataWidth/ByteSize-1:0]                                 bus_byte_enable,
  output logic                                                          bus_read,
  output logic                                                          bus_write,
  output logic [DataWidth-1:0]                                          bus_data_ctp,
  input  logic [DataWidth-1:0]                                          bus_data_ptc,
  input  logic [ByteAddressWidth-1:0]                                   address,
  input  logic [$clog2($clog2(DataWidth/ByteSize)+1):0]                 sign_size,
  input  logic                                                          rd,
  input  logic                                                          wr,
  input  logic [DataWidth-1:0]                                          data_in,
  output logic [DataWidth-1:0]                                          data_out,
  output logic                                                          malign,
  output logic                                                          complete_read,
  output logic                                                          complete_write,
  output logic                                                          busy
);
  localparam int Bpw      = DataWidth / ByteSize;
  localparam int MaxSize  = $clog2(Bpw);
  localparam int SizeSize = $clog2(MaxSize + 1);
  localparam int Waw      = ByteAddressWidth - MaxSize;
  localparam int Sw       = $clog2(DataWidth);
`ifdef MEM_SPLIT_MISALIGN_EN
  localparam bit Split = 1'b1;
`else
  localparam bit Split = 1'b0;
`endif
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SECOND = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]                  state, nxt;
  logic [ByteAddressWidth-1:0] addr_q, a;
  logic [SizeSize:0]           ss_q, ss;
  logic [DataWidth-1:0]        din_q, d;
  logic                        rd_q, op_rd;
  logic                        idle, second, crosses, illegal, active, accept, load;
  logic [SizeSize-1:0]         size;
  logic [MaxSize-1:0]          start;
  logic [MaxSize+1:0]          nb, fin;
  logic [2*Bpw-1:0]            m;
  logic [Sw-1:0]               sh_amt;
  logic [2*DataWidth-1:0]      wide_wr;
  logic [Waw-1:0]              word;
  logic [DataWidth-1:0]        lo, hi, sh, mask, rd_ext;
  logic                        msb;

  // Live inputs drive the first beat; the sampled copies keep later beats stable.
  always_comb begin
    idle    = state == IDLE;
    second  = state == SECOND;
    a       = idle ? address : addr_q;
    ss      = idle ? sign_size : ss_q;
    d       = idle ? data_in : din_q;
    op_rd   = idle ? rd : rd_q;
    size    = ss[SizeSize-1:0];
    start   = a[MaxSize-1:0];
    word    = a[ByteAddressWidth-1:MaxSize];
    nb      = (MaxSize+2)'(1) << size;
    fin     = {2'b00, start} + nb;
    crosses = fin > (MaxSize+2)'(Bpw);
    illegal = size > SizeSize'(MaxSize) || (crosses && !Split);
    malign  = idle && (rd || wr) && illegal;
    active  = (idle && (rd || wr) && !illegal) || second;
    accept  = active && bus_available;
    load    = accept && op_rd && (second || !crosses);
    m       = (((2*Bpw)'(1) << nb) - (2*Bpw)'(1)) << start;
    sh_amt  = {start, {$clog2(ByteSize){1'b0}}};
    wide_wr = {{DataWidth{1'b0}}, d} << sh_amt;
    nxt     = !accept ? (state == DONE ? IDLE : state) : (idle && crosses) ? SECOND : op_rd ? DONE : IDLE;
  end

  assign bus_address     = bus_available ? (second ? word + Waw'(1) : word) : 'z;
  assign bus_byte_enable = bus_available ? (second ? m[2*Bpw-1:Bpw] : m[Bpw-1:0]) : 'z;
  assign bus_read        = bus_available ? active && op_rd : 1'bz;
  assign bus_write       = bus_available ? active && !op_rd : 1'bz;
  assign bus_data_ctp    = bus_available ? (second ? wide_wr[2*DataWidth-1:DataWidth] : wide_wr[DataWidth-1:0]) : 'z;
  assign complete_write  = accept && !op_rd && (second || !crosses);
  assign complete_read   = state == DONE;
  assign busy            = !idle;

`ifdef MEM_SPLIT_MISALIGN_EN
  logic [DataWidth-1:0] buf_q;
  // Low half is captured on the edge that enters SECOND and held across any stall.
  always_ff @(posedge clk) begin
    if (!rst_n) buf_q <= '0;
    else if (idle && accept && crosses) buf_q <= bus_data_ptc;
  end
  assign lo = second ? buf_q : bus_data_ptc;
  assign hi = second ? bus_data_ptc : '0;
`else
  assign lo = bus_data_ptc;
  assign hi = '0;
`endif

  always_comb begin
    sh     = DataWidth'({hi, lo} >> sh_amt);
    mask   = ~({DataWidth{1'b1}} << (ByteSize << size));
    msb    = |(sh & mask & ~(mask >> 1));
    rd_ext = (sh & mask) | ({DataWidth{~ss[SizeSize] & msb}} & ~mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      ss_q     <= '0;
      din_q    <= '0;
      rd_q     <= 1'b0;
      data_out <= '0;
    end else begin
      state <= nxt;
      if (idle && accept) begin
        addr_q <= address;
        ss_q   <= sign_size;
        din_q  <= data_in;
        rd_q   <= rd;
      end
      if (load) data_out <= rd_ext;
    end
  end
endmodule

// File: tb/tb_mem_split_interface.sv
// tb_mem_split_interface: directed checks of mem_split_interface against a combinational word memory.
module tb_mem_split_interface;
  logic        clk = 1'b0;
  logic        rst_n, bus_available, rd, wr;
  logic [31:0] address, data_in, bus_data_ptc;
  logic [2:0]  sign_size;
  wire  [29:0] bus_address;
  wire  [3:0]  bus_byte_enable;
  wire         bus_read, bus_write;
  wire  [31:0] bus_data_ctp;
  logic [31:0] data_out;
  logic        malign, complete_read, complete_write, busy;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_split_interface dut (
    .clk(clk), .rst_n(rst_n), .bus_available(bus_available), .bus_address(bus_address),
    .bus_byte_enable(bus_byte_enable), .bus_read(bus_read), .bus_write(bus_write),
    .bus_data_ctp(bus_data_ctp), .bus_data_ptc(bus_data_ptc), .address(address),
    .sign_size(sign_size), .rd(rd), .wr(wr), .data_in(data_in), .data_out(data_out),
    .malign(malign), .complete_read(complete_read), .complete_write(complete_write), .busy(busy)
  );

  function automatic logic [31:0] memw(input logic [29:0] w);
    return w == 30'h400 ? 32'h44332211 : w == 30'h401 ? 32'h88776655 :
           w == 30'h3FFFFFFF ? 32'hCAFEF00D : w == 30'h0 ? 32'h12345678 : 32'h0;
  endfunction

  assign bus_data_ptc = memw(bus_address);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic r, input logic w, input logic [31:0] adr, input logic [2:0] ss, input logic [31:0] din);
    rd = r; wr = w; address = adr; sign_size = ss; data_in = din;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; bus_available = 1'b1; rd = 0; wr = 0; address = 0; sign_size = 0; data_in = 0;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_cr", complete_read, 0);
    chk("rst_dout", data_out, 0);
    rst_n = 1'b1;
    tick;
    chk("idle_malign", malign, 0);
    chk("idle_read", bus_read, 0);

    req(1, 0, 32'h1007, 3'b000, 0);
    chk("lb_addr", bus_address, 30'h401);
    chk("lb_be", bus_byte_enable, 4'b1000);
    chk("lb_rd", bus_read, 1);
    chk("lb_cr_early", complete_read, 0);
    tick;
    chk("lb_cr", complete_read, 1);
    chk("lb_data", data_out, 32'hFFFFFF88);
    rd = 0;
    tick;
    chk("lb_cr_pulse", complete_read, 0);
    chk("lb_idle", busy, 0);

    req(1, 0, 32'h1007, 3'b100, 0);
    tick;
    chk("lbu_data", data_out, 32'h00000088);
    rd = 0; tick;

    req(1, 0, 32'h1006, 3'b001, 0);
    chk("lh_be", bus_byte_enable, 4'b1100);
    tick;
    chk("lh_data", data_out, 32'hFFFF8877);
    rd = 0; tick;

    req(1, 1, 32'h1000, 3'b010, 32'hDEADBEEF);
    chk("rdwr_rd", bus_read, 1);
    chk("rdwr_wr", bus_write, 0);
    chk("rdwr_cw", complete_write, 0);
    tick;
    chk("rdwr_data", data_out, 32'h44332211);
    rd = 0; wr = 0; tick;

    req(0, 1, 32'h1004, 3'b010, 32'h11223344);
    chk("sw_wr", bus_write, 1);
    chk("sw_be", bus_byte_enable, 4'b1111);
    chk("sw_data", bus_data_ctp, 32'h11223344);
    chk("sw_cw", complete_write, 1);
    wr = 0;
    tick;
    chk("sw_busy", busy, 0);

    req(0, 1, 32'h1002, 3'b000, 32'h000000AB);
    chk("sb_be", bus_byte_enable, 4'b0100);
    chk("sb_data", bus_data_ctp, 32'h00AB0000);
    chk("sb_cw", complete_write, 1);
    wr = 0; tick;

    req(1, 0, 32'h1000, 3'b011, 0);
    chk("sz3_malign", malign, 1);
    chk("sz3_rd", bus_read, 0);
    chk("sz3_wr", bus_write, 0);
    tick;
    chk("sz3_busy", busy, 0);
    chk("sz3_cr", complete_read, 0);
    rd = 0; tick;

    bus_available = 0;
    req(1, 0, 32'h1000, 3'b010, 0);
    tick;
    chk("stall0_busy", busy, 0);
    chk("stall0_cr", complete_read, 0);
    bus_available = 1; #1;
    chk("stall0_rd", bus_read, 1);
    tick;
    chk("stall0_data", data_out, 32'h44332211);
    chk("stall0_cr2", complete_read, 1);
    rd = 0; tick;

`ifdef MEM_SPLIT_MISALIGN_EN
    req(1, 0, 32'h1002, 3'b010, 0);
    chk("lw_b0_addr", bus_address, 30'h400);
    chk("lw_b0_be", bus_byte_enable, 4'b1100);
    chk("lw_malign", malign, 0);
    tick;
    address = 32'h0; sign_size = 3'b000; #1;
    chk("lw_b1_addr", bus_address, 30'h401);
    chk("lw_b1_be", bus_byte_enable, 4'b0011);
    chk("lw_b1_cr", complete_read, 0);
    tick;
    chk("lw_cr", complete_read, 1);
    chk("lw_data", data_out, 32'h66554433);
    rd = 0; tick;
    chk("lw_idle", busy, 0);

    req(1, 0, 32'h1003, 3'b001, 0);
    chk("lh3_b0_be", bus_byte_enable, 4'b1000);
    tick;
    chk("lh3_b1_be", bus_byte_enable, 4'b0001);
    tick;
    chk("lh3_data", data_out, 32'h00005544);
    rd = 0; tick;

    req(0, 1, 32'h1001, 3'b010, 32'hAABBCCDD);
    chk("sws_b0_be", bus_byte_enable, 4'b1110);
    chk("sws_b0_data", bus_data_ctp, 32'hBBCCDD00);
    chk("sws_b0_cw", complete_write, 0);
    tick;
    chk("sws_b1_addr", bus_address, 30'h401);
    chk("sws_b1_be", bus_byte_enable, 4'b0001);
    chk("sws_b1_data", bus_data_ctp, 32'h000000AA);
    chk("sws_b1_cw", complete_write, 1);
    wr = 0; tick;
    chk("sws_idle", busy, 0);

    req(1, 0, 32'h1002, 3'b010, 0);
    tick;
    bus_available = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall1_cr", complete_read, 0);
      chk("stall1_busy", busy, 1);
      tick;
    end
    bus_available = 1; #1;
    chk("stall1_addr", bus_address, 30'h401);
    tick;
    chk("stall1_cr2", complete_read, 1);
    chk("stall1_data", data_out, 32'h66554433);
    rd = 0; tick;

    req(0, 1, 32'hFFFFFFFF, 3'b001, 32'h0000BEEF);
    chk("wrap_b0_addr", bus_address, 30'h3FFFFFFF);
    chk("wrap_b0_be", bus_byte_enable, 4'b1000);
    chk("wrap_b0_data", bus_data_ctp, 32'hEF000000);
    tick;
    chk("wrap_b1_addr", bus_address, 30'h0);
    chk("wrap_b1_be", bus_byte_enable, 4'b0001);
    chk("wrap_b1_data", bus_data_ctp, 32'h000000BE);
    chk("wrap_b1_cw", complete_write, 1);
    wr = 0; tick;

    req(1, 0, 32'h1002, 3'b010, 0);
    tick;
    rst_n = 0;
    tick;
    rd = 0; rst_n = 1; #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_cr", complete_read, 0);
    tick;
    chk("rstmid_cr2", complete_read, 0);
    chk("rstmid_dout", data_out, 0);
`else
    req(1, 0, 32'h1002, 3'b010, 0);
    chk("nosplit_lw_malign", malign, 1);
    chk("nosplit_lw_rd", bus_read, 0);
    tick;
    chk("nosplit_lw_busy", busy, 0);
    chk("nosplit_lw_cr", complete_read, 0);
    rd = 0; tick;

    req(0, 1, 32'h1001, 3'b010, 32'hAABBCCDD);
    chk("nosplit_sw_malign", malign, 1);
    chk("nosplit_sw_wr", bus_write, 0);
    chk("nosplit_sw_cw", complete_write, 0);
    wr = 0; tick;

    req(1, 0, 32'h1003, 3'b001, 0);
    chk("nosplit_lh3_malign", malign, 1);
    rd = 0; tick;

    req(1, 0, 32'h1002, 3'b001, 0);
    chk("nosplit_lh2_malign", malign, 0);
    chk("nosplit_lh2_be", bus_byte_enable, 4'b1100);
    tick;
    chk("nosplit_lh2_data", data_out, 32'h00004433);
    rd = 0; tick;

    req(1, 0, 32'h1004, 3'b010, 0);
    tick;
    rst_n = 0; rd = 0;
    tick;
    rst_n = 1; #1;
    chk("rst_done_busy", busy, 0);
    chk("rst_done_cr", complete_read, 0);
    chk("rst_done_dout", data_out, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
